p_perm_pipe: RTL and testbench

- Parametrised, pipelined successor to the 3-channel controlled permutation cell.
- Forward pass: applies a control-selected permutation to a CHANNELS-wide vector.
- Backward pass: applies the inverse permutation using the control value recorded during the forward pass, and emits a control-sensitivity bit.
- Sits in the bitnet datapath between layers. Forward and backward streams each use a valid/ready handshake and are decoupled by an internal control FIFO.

---
 rtl/p_perm_pipe_if.sv | 42 ++++
 rtl/p_perm_pipe.sv | 104 ++++++++++
 tb/tb_p_perm_pipe.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_perm_pipe_if.sv
// Handshake bundle for p_perm_pipe: forward stream, backward stream and FIFO occupancy.
// The slave side is the pipeline itself; the master side is the surrounding datapath.
interface p_perm_pipe_if #(
   parameter int CHANNELS = 3,
   parameter int DEPTH    = 8
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic                f_valid_in;
   logic                f_ready_out;
   logic                fcontrol;
   logic [CHANNELS-1:0] fin;
   logic                f_valid_out;
   logic                f_ready_in;
   logic [CHANNELS-1:0] fout;

   logic                b_valid_in;
   logic                b_ready_out;
   logic [CHANNELS-1:0] bin;
   logic                b_valid_out;
   logic                b_ready_in;
   logic [CHANNELS-1:0] bout;
   logic                bcontrol;

   logic [PW-1:0]       pending;

   modport slave (
      input  f_valid_in, fcontrol, fin, f_ready_in,
      input  b_valid_in, bin, b_ready_in,
      output f_ready_out, f_valid_out, fout,
      output b_ready_out, b_valid_out, bout, bcontrol,
      output pending
   );

   modport master (
      output f_valid_in, fcontrol, fin, f_ready_in,
      output b_valid_in, bin, b_ready_in,
      input  f_ready_out, f_valid_out, fout,
      input  b_ready_out, b_valid_out, bout, bcontrol,
      input  pending
   );
endinterface

// File: rtl/p_perm_pipe.sv
// Pipelined controlled permutation: forward rotate by control, backward inverse rotate
// using the control recorded on the forward pass (FIFO order), plus a sensitivity bit.
module p_perm_pipe #(
   parameter int CHANNELS = 3,
   parameter int DEPTH    = 8
) (
   input logic          clk_in,
   input logic          rst_in,
   p_perm_pipe_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   function automatic logic [CHANNELS-1:0] perm_fwd(input logic c, input logic [CHANNELS-1:0] x);
      perm_fwd = c ? {x[0], x[CHANNELS-1:1]} : x;
   endfunction

   function automatic logic [CHANNELS-1:0] perm_inv(input logic c, input logic [CHANNELS-1:0] x);
      perm_inv = c ? {x[CHANNELS-2:0], x[CHANNELS-1]} : x;
   endfunction

   logic [DEPTH-1:0]    r_ctl_mem;
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [PW-1:0]       r_pending;

   logic                r_f_valid;
   logic [CHANNELS-1:0] r_fout;
   logic                r_b_valid;
   logic [CHANNELS-1:0] r_bout;
   logic                r_bcontrol;

   logic                w_fwd_slot_free;
   logic                w_bwd_slot_free;
   logic                w_f_ready;
   logic                w_b_ready;
   logic                w_push;
   logic                w_pop;
   logic                w_pop_ctl;
   logic [CHANNELS-1:0] w_bout_sel;
   logic [CHANNELS-1:0] w_bout_alt;

   assign w_fwd_slot_free = !r_f_valid || bus.f_ready_in;
   assign w_bwd_slot_free = !r_b_valid || bus.b_ready_in;

   // Readiness looks only at registered occupancy, so a full FIFO never accepts
   // on a same-cycle pop and an empty one never pops a same-cycle push.
   assign w_f_ready = !rst_in && w_fwd_slot_free && (r_pending < PW'(DEPTH));
   assign w_b_ready = !rst_in && w_bwd_slot_free && (r_pending != '0);

   assign w_push    = bus.f_valid_in && w_f_ready;
   assign w_pop     = bus.b_valid_in && w_b_ready;
   assign w_pop_ctl = r_ctl_mem[r_rd_ptr];

   assign w_bout_sel = perm_inv(w_pop_ctl, bus.bin);
   assign w_bout_alt = perm_inv(!w_pop_ctl, bus.bin);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_ctl_mem  <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pending  <= '0;
         r_f_valid  <= 1'b0;
         r_fout     <= '0;
         r_b_valid  <= 1'b0;
         r_bout     <= '0;
         r_bcontrol <= 1'b0;
      end else begin
         if (w_push) begin
            r_ctl_mem[r_wr_ptr] <= bus.fcontrol;
            r_wr_ptr            <= r_wr_ptr + AW'(1);
            r_fout              <= perm_fwd(bus.fcontrol, bus.fin);
            r_f_valid           <= 1'b1;
         end else if (bus.f_ready_in) begin
            r_f_valid <= 1'b0;
         end

         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_bout     <= w_bout_sel;
            r_bcontrol <= (w_bout_sel != w_bout_alt);
            r_b_valid  <= 1'b1;
         end else if (bus.b_ready_in) begin
            r_b_valid <= 1'b0;
         end

         case ({w_push, w_pop})
            2'b10:   r_pending <= r_pending + PW'(1);
            2'b01:   r_pending <= r_pending - PW'(1);
            default: r_pending <= r_pending;
         endcase
      end
   end

   assign bus.f_ready_out = w_f_ready;
   assign bus.f_valid_out = r_f_valid;
   assign bus.fout        = r_fout;
   assign bus.b_ready_out = w_b_ready;
   assign bus.b_valid_out = r_b_valid;
   assign bus.bout        = r_bout;
   assign bus.bcontrol    = r_bcontrol;
   assign bus.pending     = r_pending;
endmodule

// File: tb/tb_p_perm_pipe.sv
// Testbench for p_perm_pipe: directed scenarios plus a randomized run checked
// against a queue-based reference model of the forward/backward streams.
module tb_p_perm_pipe;
   localparam int CH = 3;
   localparam int DP = 8;
   localparam int PW = $clog2(DP) + 1;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_in = ~clk_in;

   p_perm_pipe_if #(.CHANNELS(CH), .DEPTH(DP)) bus ();

   p_perm_pipe #(.CHANNELS(CH), .DEPTH(DP)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   function automatic logic [CH-1:0] m_perm(input bit c, input logic [CH-1:0] x);
      logic [CH-1:0] y;
      for (int i = 0; i < CH; i++) y[i] = c ? x[(i + 1) % CH] : x[i];
      return y;
   endfunction

   function automatic logic [CH-1:0] m_inv(input bit c, input logic [CH-1:0] x);
      logic [CH-1:0] y;
      for (int i = 0; i < CH; i++) y[i] = c ? x[(i + CH - 1) % CH] : x[i];
      return y;
   endfunction

   task automatic drive(input bit fv, input bit fc, input logic [CH-1:0] fi, input bit fr,
                        input bit bv, input logic [CH-1:0] bi, input bit br);
      bus.f_valid_in = fv;
      bus.fcontrol   = fc;
      bus.fin        = fi;
      bus.f_ready_in = fr;
      bus.b_valid_in = bv;
      bus.bin        = bi;
      bus.b_ready_in = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, '0, 1, 0, '0, 1);
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      idle();
      tick();
      checks++;
      if (bus.f_ready_out !== 1'b0) begin errors++; $display("FAIL rst_fready_during got %b exp 0", bus.f_ready_out); end
      tick();
      rst_in = 1'b0;
      #1;
      checks++;
      if (bus.f_valid_out !== 1'b0 || bus.b_valid_out !== 1'b0) begin
         errors++; $display("FAIL rst_valids got %b%b exp 00", bus.f_valid_out, bus.b_valid_out);
      end
      checks++;
      if (bus.fout !== '0 || bus.bout !== '0 || bus.bcontrol !== 1'b0) begin
         errors++; $display("FAIL rst_data got fout=%b bout=%b bc=%b exp zeros", bus.fout, bus.bout, bus.bcontrol);
      end
      checks++;
      if (bus.pending !== PW'(0)) begin errors++; $display("FAIL rst_pending got %0d exp 0", bus.pending); end
      checks++;
      if (bus.f_ready_out !== 1'b1 || bus.b_ready_out !== 1'b0) begin
         errors++; $display("FAIL rst_readys got f=%b b=%b exp f=1 b=0", bus.f_ready_out, bus.b_ready_out);
      end
   endtask

   task automatic test_fwd_bwd_ctrl1();
      drive(1, 1, 3'b001, 1, 0, '0, 1);
      tick();
      checks++;
      if (bus.fout !== 3'b100 || bus.f_valid_out !== 1'b1) begin
         errors++; $display("FAIL fb1_fout got %b v=%b exp 100 v=1", bus.fout, bus.f_valid_out);
      end
      checks++;
      if (bus.pending !== PW'(1)) begin errors++; $display("FAIL fb1_pending1 got %0d exp 1", bus.pending); end
      drive(0, 0, '0, 1, 1, 3'b100, 1);
      checks++;
      if (bus.b_ready_out !== 1'b1) begin errors++; $display("FAIL fb1_bready got %b exp 1", bus.b_ready_out); end
      tick();
      checks++;
      if (bus.bout !== 3'b001 || bus.bcontrol !== 1'b1 || bus.b_valid_out !== 1'b1) begin
         errors++; $display("FAIL fb1_bout got %b bc=%b v=%b exp 001 bc=1 v=1", bus.bout, bus.bcontrol, bus.b_valid_out);
      end
      checks++;
      if (bus.pending !== PW'(0) || bus.f_valid_out !== 1'b0) begin
         errors++; $display("FAIL fb1_pending0 got %0d fv=%b exp 0 fv=0", bus.pending, bus.f_valid_out);
      end
      idle();
      tick();
   endtask

   task automatic test_insensitive();
      drive(1, 0, 3'b010, 1, 0, '0, 1);
      tick();
      checks++;
      if (bus.fout !== 3'b010) begin errors++; $display("FAIL ins_fout got %b exp 010", bus.fout); end
      drive(0, 0, '0, 1, 1, 3'b111, 1);
      tick();
      checks++;
      if (bus.bout !== 3'b111 || bus.bcontrol !== 1'b0) begin
         errors++; $display("FAIL ins_bout got %b bc=%b exp 111 bc=0", bus.bout, bus.bcontrol);
      end
      idle();
      tick();
   endtask

   task automatic test_fifo_order();
      bit            ctl [3];
      logic [CH-1:0] expv [3];
      ctl[0] = 1; ctl[1] = 0; ctl[2] = 1;
      expv[0] = 3'b010; expv[1] = 3'b001; expv[2] = 3'b010;
      for (int i = 0; i < 3; i++) begin
         drive(1, ctl[i], 3'b011, 1, 0, '0, 1);
         tick();
      end
      checks++;
      if (bus.pending !== PW'(3)) begin errors++; $display("FAIL ord_pending got %0d exp 3", bus.pending); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, '0, 1, 1, 3'b001, 1);
         tick();
         checks++;
         if (bus.bout !== expv[i]) begin errors++; $display("FAIL ord_bout%0d got %b exp %b", i, bus.bout, expv[i]); end
      end
      idle();
      tick();
   endtask

   task automatic test_full();
      for (int i = 0; i < DP; i++) begin
         drive(1, 1, 3'b101, 1, 0, '0, 1);
         tick();
      end
      drive(1, 1, 3'b101, 1, 0, '0, 1);
      checks++;
      if (bus.pending !== PW'(DP) || bus.f_ready_out !== 1'b0) begin
         errors++; $display("FAIL full_state got pend=%0d fr=%b exp 8 fr=0", bus.pending, bus.f_ready_out);
      end
      drive(1, 0, 3'b101, 1, 1, 3'b000, 1);
      checks++;
      if (bus.f_ready_out !== 1'b0 || bus.b_ready_out !== 1'b1) begin
         errors++; $display("FAIL full_popcycle got fr=%b br=%b exp fr=0 br=1", bus.f_ready_out, bus.b_ready_out);
      end
      tick();
      drive(0, 0, '0, 1, 0, '0, 1);
      checks++;
      if (bus.pending !== PW'(DP - 1) || bus.f_ready_out !== 1'b1) begin
         errors++; $display("FAIL full_after got pend=%0d fr=%b exp 7 fr=1", bus.pending, bus.f_ready_out);
      end
      for (int i = 0; i < DP - 1; i++) begin
         drive(0, 0, '0, 1, 1, 3'b000, 1);
         tick();
      end
      idle();
      tick();
      checks++;
      if (bus.pending !== PW'(0)) begin errors++; $display("FAIL full_drain got %0d exp 0", bus.pending); end
   endtask

   task automatic test_backpressure();
      drive(1, 1, 3'b110, 0, 0, '0, 1);
      tick();
      drive(1, 0, 3'b001, 0, 0, '0, 1);
      checks++;
      if (bus.f_ready_out !== 1'b0) begin errors++; $display("FAIL bp_fready got %b exp 0", bus.f_ready_out); end
      tick();
      checks++;
      if (bus.fout !== 3'b011 || bus.f_valid_out !== 1'b1 || bus.pending !== PW'(1)) begin
         errors++; $display("FAIL bp_hold got fout=%b v=%b pend=%0d exp 011 v=1 1", bus.fout, bus.f_valid_out, bus.pending);
      end
      drive(0, 0, '0, 1, 1, 3'b100, 0);
      tick();
      checks++;
      if (bus.f_valid_out !== 1'b0 || bus.bout !== 3'b001 || bus.b_valid_out !== 1'b1) begin
         errors++; $display("FAIL bp_bwd got fv=%b bout=%b bv=%b exp 0 001 1", bus.f_valid_out, bus.bout, bus.b_valid_out);
      end
      drive(0, 0, '0, 1, 1, 3'b111, 1);
      checks++;
      if (bus.b_ready_out !== 1'b0) begin errors++; $display("FAIL bp_empty_bready got %b exp 0", bus.b_ready_out); end
      tick();
      checks++;
      if (bus.b_valid_out !== 1'b0 || bus.bout !== 3'b001 || bus.pending !== PW'(0)) begin
         errors++; $display("FAIL bp_empty_after got bv=%b bout=%b pend=%0d exp 0 001 0", bus.b_valid_out, bus.bout, bus.pending);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 3'b110, 1, 0, '0, 1);
         tick();
      end
      drive(1, 0, 3'b010, 1, 1, 3'b010, 1);
      tick();
      drive(0, 0, '0, 0, 0, '0, 0);
      checks++;
      if (bus.pending !== PW'(3) || bus.f_valid_out !== 1'b1 || bus.b_valid_out !== 1'b1) begin
         errors++; $display("FAIL rm_pre got pend=%0d fv=%b bv=%b exp 3 1 1", bus.pending, bus.f_valid_out, bus.b_valid_out);
      end
      rst_in = 1'b1;
      #1;
      checks++;
      if (bus.f_ready_out !== 1'b0 || bus.b_ready_out !== 1'b0) begin
         errors++; $display("FAIL rm_readys got f=%b b=%b exp 0 0", bus.f_ready_out, bus.b_ready_out);
      end
      tick();
      rst_in = 1'b0;
      #1;
      checks++;
      if (bus.f_valid_out !== 1'b0 || bus.b_valid_out !== 1'b0 || bus.pending !== PW'(0)) begin
         errors++; $display("FAIL rm_state got fv=%b bv=%b pend=%0d exp 0 0 0", bus.f_valid_out, bus.b_valid_out, bus.pending);
      end
      checks++;
      if (bus.fout !== '0 || bus.bout !== '0 || bus.bcontrol !== 1'b0) begin
         errors++; $display("FAIL rm_data got fout=%b bout=%b bc=%b exp zeros", bus.fout, bus.bout, bus.bcontrol);
      end
      idle();
      tick();
   endtask

   task automatic test_random();
      bit            q [$];
      logic [CH-1:0] m_fout = '0;
      logic [CH-1:0] m_bout = '0;
      bit            m_fv = 0, m_bv = 0, m_bc = 0;
      bit            fv, fc, fr, bv, br, exp_fr, exp_br, c;
      logic [CH-1:0] fi, bi;
      int            pf, pb;
      for (int n = 0; n < 3000; n++) begin
         pf = ((n / 250) % 2 == 0) ? 80 : 25;
         pb = ((n / 250) % 2 == 0) ? 25 : 80;
         @(negedge clk_in);
         fv = ($urandom_range(0, 99) < pf);
         fc = 1'($urandom);
         fi = CH'($urandom);
         fr = ($urandom_range(0, 99) < 70);
         bv = ($urandom_range(0, 99) < pb);
         bi = CH'($urandom);
         br = ($urandom_range(0, 99) < 70);
         drive(fv, fc, fi, fr, bv, bi, br);
         exp_fr = (!m_fv || fr) && (q.size() < DP);
         exp_br = (!m_bv || br) && (q.size() > 0);
         checks++;
         if (bus.f_ready_out !== exp_fr) begin errors++; $display("FAIL rnd_fready n=%0d got %b exp %b", n, bus.f_ready_out, exp_fr); end
         checks++;
         if (bus.b_ready_out !== exp_br) begin errors++; $display("FAIL rnd_bready n=%0d got %b exp %b", n, bus.b_ready_out, exp_br); end
         if (bv && exp_br) begin
            c      = q.pop_front();
            m_bout = m_inv(c, bi);
            m_bc   = (m_inv(c, bi) != m_inv(!c, bi));
            m_bv   = 1;
         end else if (br) begin
            m_bv = 0;
         end
         if (fv && exp_fr) begin
            q.push_back(fc);
            m_fout = m_perm(fc, fi);
            m_fv   = 1;
         end else if (fr) begin
            m_fv = 0;
         end
         tick();
         checks++;
         if (bus.f_valid_out !== m_fv || bus.fout !== m_fout) begin
            errors++; $display("FAIL rnd_fwd n=%0d got v=%b fout=%b exp v=%b fout=%b", n, bus.f_valid_out, bus.fout, m_fv, m_fout);
         end
         checks++;
         if (bus.b_valid_out !== m_bv || bus.bout !== m_bout || bus.bcontrol !== m_bc) begin
            errors++; $display("FAIL rnd_bwd n=%0d got v=%b bout=%b bc=%b exp v=%b bout=%b bc=%b",
                               n, bus.b_valid_out, bus.bout, bus.bcontrol, m_bv, m_bout, m_bc);
         end
         checks++;
         if (bus.pending !== PW'(q.size())) begin
            errors++; $display("FAIL rnd_pending n=%0d got %0d exp %0d", n, bus.pending, q.size());
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fwd_bwd_ctrl1();
      test_insensitive();
      test_fifo_order();
      test_full();
      test_backpressure();
      test_reset_mid();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
